butterfly_tx: RTL and testbench

BUTTERFLY_TX -- requirements
Module: butterfly_tx

---
 rtl/butterfly_pkg.sv | 13 +
 rtl/butterfly_tx_fifo.sv | 45 ++++
 rtl/butterfly_tx.sv | 120 ++++++++++++
 tb/tb_butterfly_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/butterfly_pkg.sv
// Definitions shared by the butterfly result transmitter and receiver:
// result framing size, default batch length and the serialiser state encoding.
package butterfly_pkg;
  localparam int RESULT_BYTES = 16;
  localparam int RESULT_BITS  = RESULT_BYTES * 8;
  localparam int NRES_DEFAULT = 10;
  localparam int BYTE_CNT_W   = $clog2(RESULT_BYTES);

  typedef enum logic {
    s_IDLE,
    s_SEND
  } state_t;
endpackage

// File: rtl/butterfly_tx_fifo.sv
// Show-ahead FIFO of DEPTH entries: data at the read pointer is visible combinationally.
// A push while full is taken only if a pop happens in the same cycle.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd      = i_pop && !o_empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_wr      = i_push && (!o_full || w_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/butterfly_tx.sv
// Queues 128-bit butterfly results and streams each as 16 big-endian bytes; first byte 2 cycles after i_valid.
// Bytes advance only on i_ready; results arriving with the queue full and no pop are dropped (sticky o_overflow).
module butterfly_tx
  import butterfly_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NRES  = NRES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [31:0] i_A_re,
  input  logic [31:0] i_A_im,
  input  logic [31:0] i_B_re,
  input  logic [31:0] i_B_im,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_overflow
);
  localparam int RCW = (NRES > 1) ? $clog2(NRES) : 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE   = BYTE_CNT_W'(RESULT_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] PENULT_BYTE = BYTE_CNT_W'(RESULT_BYTES - 2);
  localparam logic [RCW-1:0]        LAST_RES    = RCW'(NRES - 1);

  logic [RESULT_BITS-1:0] w_push_dat;
  logic [RESULT_BITS-1:0] w_fifo_dat;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_acc;
  logic                   w_res_done;
  logic                   w_pop;

  state_t                 r_state;
  logic [RESULT_BITS-9:0] r_shift;
  logic [BYTE_CNT_W-1:0]  r_byte_cnt;
  logic [RCW-1:0]         r_res_cnt;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_overflow;

  assign w_push_dat = {i_A_re, i_A_im, i_B_re, i_B_im};
  assign w_acc      = (r_state == s_SEND) && i_ready;
  assign w_res_done = w_acc && (r_byte_cnt == LAST_BYTE);
  // Popping on the final byte's handshake keeps back-to-back results gapless.
  assign w_pop      = !w_empty && ((r_state == s_IDLE) || w_res_done);

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RESULT_BITS)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_valid),
    .i_wr_data (w_push_dat),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_dat),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= s_IDLE;
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_res_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (i_valid && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_res_done) r_res_cnt <= (r_res_cnt == LAST_RES) ? '0 : r_res_cnt + 1'b1;

      case (r_state)
        s_IDLE: begin
          if (!w_empty) begin
            r_state    <= s_SEND;
            r_shift    <= w_fifo_dat[RESULT_BITS-9:0];
            r_byte_cnt <= '0;
            r_data     <= w_fifo_dat[RESULT_BITS-1 -: 8];
            r_valid    <= 1'b1;
            r_last     <= 1'b0;
          end
        end
        s_SEND: begin
          if (i_ready) begin
            if (w_res_done) begin
              if (!w_empty) begin
                r_shift    <= w_fifo_dat[RESULT_BITS-9:0];
                r_byte_cnt <= '0;
                r_data     <= w_fifo_dat[RESULT_BITS-1 -: 8];
                r_last     <= 1'b0;
              end else begin
                r_state    <= s_IDLE;
                r_data     <= '0;
                r_valid    <= 1'b0;
                r_last     <= 1'b0;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
              r_shift    <= {r_shift[RESULT_BITS-17:0], 8'h00};
              r_data     <= r_shift[RESULT_BITS-9 -: 8];
              r_last     <= (r_byte_cnt == PENULT_BYTE) && (r_res_cnt == LAST_RES);
            end
          end
        end
        default: r_state <= s_IDLE;
      endcase
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_last     = r_last;
  assign o_overflow = r_overflow;
endmodule

// File: tb/tb_butterfly_tx.sv
// Directed-plus-random bench for butterfly_tx: expected byte streams come from a result-level model.
module tb_butterfly_tx;
  import butterfly_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int TB_NRES  = 10;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] a_re, a_im, b_re, b_im;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_overflow;

  int checks;
  int errors;
  int mres;
  int run_len;
  logic [8:0] cap[$];
  logic [8:0] exp_q[$];

  butterfly_tx #(
    .DEPTH (TB_DEPTH),
    .NRES  (TB_NRES)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .i_A_re     (a_re),
    .i_A_im     (a_im),
    .i_B_re     (b_re),
    .i_B_im     (b_im),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted byte (valid and ready at the coming edge) with its last flag.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) cap.push_back({o_last, o_data});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: each result becomes 16 MSB-first bytes; last flag on byte 15 of every NRES-th result.
  task automatic add_result(input logic [127:0] r);
    for (int b = 0; b < RESULT_BYTES; b++)
      exp_q.push_back({(b == RESULT_BYTES - 1) && (mres == TB_NRES - 1), r[127 - 8*b -: 8]});
    mres = (mres + 1) % TB_NRES;
  endtask

  task automatic push(input logic [127:0] r);
    @(posedge clk); #1;
    i_valid = 1'b1;
    {a_re, a_im, b_re, b_im} = r;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cap.delete();
    exp_q.delete();
    mres = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    int idle;
    n = 0;
    idle = 0;
    while (idle < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (o_valid) idle = 0;
      else idle++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [127:0] r;
    logic [8:0]   e;
    logic [7:0]   pd;
    logic         pv, pr, pl;
    int           w;

    checks = 0;
    errors = 0;
    mres = 0;
    rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    {a_re, a_im, b_re, b_im} = '0;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cap.delete();

    // Single fixed result: latency, 16-cycle valid window, byte order
    r = {32'h3F800000, 32'h40000000, 32'hBF800000, 32'h00000000};
    add_result(r);
    @(posedge clk); #1;
    i_valid = 1'b1;
    {a_re, a_im, b_re, b_im} = r;
    @(negedge clk);
    chk("lat_c0", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1", 32'(o_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(o_valid), 32'd1);
    chk("first_byte", 32'(o_data), 32'h3F);
    run_len = 0;
    while (o_valid && run_len < 40) begin
      run_len++;
      @(negedge clk);
    end
    chk("single_vcycles", run_len, 32'd16);
    drain("single", 100);
    cmp_stream("single");

    // Backpressure: i_ready alternating, bytes must hold while stalled
    do_reset();
    r = {$urandom, $urandom, $urandom, $urandom};
    add_result(r);
    i_ready = 1'b1;
    push(r);
    pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (pv && !pr) begin
        chk($sformatf("hold_data_c%0d", c), 32'(o_data), 32'(pd));
        chk($sformatf("hold_last_c%0d", c), 32'(o_last), 32'(pl));
      end
      pv = o_valid; pr = i_ready; pd = o_data; pl = o_last;
      @(posedge clk); #1;
      i_ready = ~i_ready;
    end
    i_ready = 1'b1;
    drain("bp", 100);
    cmp_stream("bp");

    // Batch of NRES results 3 cycles apart: contiguous bytes, last on byte 160 only
    do_reset();
    run_len = 0;
    fork
      begin
        for (int k = 0; k < TB_NRES; k++) begin
          r = {$urandom, $urandom, $urandom, $urandom};
          add_result(r);
          push(r);
          @(posedge clk);
        end
      end
      begin
        int wv;
        wv = 0;
        @(negedge clk);
        while (!o_valid && wv < 100) begin
          @(negedge clk);
          wv++;
        end
        while (o_valid && run_len < 400) begin
          run_len++;
          @(negedge clk);
        end
      end
    join
    chk("batch_contig", run_len, 32'd160);
    drain("batch", 100);
    cmp_stream("batch");
    chk("batch_ovf", 32'(o_overflow), 32'd0);

    // Reset at byte 7 of the 4th result; nothing resumes, batch count restarts
    do_reset();
    for (int k = 0; k < 4; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      add_result(r);
      push(r);
      @(posedge clk);
    end
    w = 0;
    while (cap.size() < 55 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rstmid_timeout", 32'(w < 300), 32'd1);
    e = exp_q[55];
    chk("rstmid_byte7", 32'(o_data), 32'(e[7:0]));
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 32'(o_valid), 32'd0);
    chk("rstmid_data", 32'(o_data), 32'd0);
    chk("rstmid_last", 32'(o_last), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cap.delete();
    exp_q.delete();
    mres = 0;
    repeat (5) @(posedge clk);
    chk("rstmid_idle", 32'(o_valid), 32'd0);
    for (int k = 0; k < TB_NRES; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      add_result(r);
      push(r);
      @(posedge clk);
    end
    drain("rstmid", 400);
    cmp_stream("rstmid");

    // Overflow: stalled sink, DEPTH+2 back-to-back pushes, DEPTH+1 survive
    do_reset();
    i_ready = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < TB_DEPTH + 2; k++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      if (k < TB_DEPTH + 1) add_result(r);
      i_valid = 1'b1;
      {a_re, a_im, b_re, b_im} = r;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    chk("ovf_stall_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #1;
    i_ready = 1'b1;
    drain("ovf", 600);
    cmp_stream("ovf");
    chk("ovf_sticky", 32'(o_overflow), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
